// File: rtl/virtual_input_sequencer.sv
// Command scheduler for the virtual button/switch decoder: buffers host command
// bytes and turns each into setup / strobe-high / gap-low sequences on number+control.
module virtual_input_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int PULSE_LEN  = 4,
   parameter int GAP_LEN    = 4,
   parameter int HOLD_LEN   = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [3:0]  number,
   output logic        control,
   output logic        busy,
   output logic [15:0] mirror,
   output logic [7:0]  err_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = 16;
   localparam logic [AW:0]  FULL_COUNT    = (AW + 1)'(FIFO_DEPTH);
   localparam logic [15:0]  DEFAULT_STATE = 16'h000F;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_SETUP, S_STROBE, S_GAP, S_HOLD, S_SCAN
   } state_e;

   typedef enum logic [1:0] {
      OP_TOGGLE = 2'b00, OP_PULSE = 2'b01, OP_CLEAR = 2'b10, OP_INVALID = 2'b11
   } opcode_e;

   typedef struct packed {
      opcode_e    op;
      logic [3:0] idx;
   } cmd_t;

   // Bits [5:4] of a command byte are reserved and never stored.
   logic unused_reserved_bits;
   assign unused_reserved_bits = ^cmd_data[5:4];

   cmd_t          fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count, fifo_count_next;
   logic          push, pop;

   state_e        state, state_next;
   cmd_t          cmd_q;
   opcode_e       op_q, op_next;
   logic          second_q, second_next;
   logic [TW-1:0] timer, timer_next;
   logic [3:0]    scan_idx, scan_next;
   logic [3:0]    number_next;
   logic [15:0]   mirror_next;
   logic [7:0]    err_next;

   assign push = cmd_valid && cmd_ready;
   assign busy = (state != S_IDLE) || (fifo_count != '0);

   always_comb begin
      fifo_count_next = fifo_count;
      if (push && !pop)      fifo_count_next = fifo_count + (AW + 1)'(1);
      else if (!push && pop) fifo_count_next = fifo_count - (AW + 1)'(1);
   end

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         cmd_ready  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count_next;
         cmd_ready  <= (fifo_count_next != FULL_COUNT);
      end
   end

   // NOTE: the storage array has no reset; flushing the pointers is enough to empty it.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_t'({cmd_data[7:6], cmd_data[3:0]});
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next  = state;
      number_next = number;
      mirror_next = mirror;
      timer_next  = timer;
      scan_next   = scan_idx;
      op_next     = op_q;
      second_next = second_q;
      err_next    = err_count;
      pop         = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (fifo_count != '0) begin
               pop        = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            op_next = cmd_q.op;
            unique case (cmd_q.op)
               OP_TOGGLE, OP_PULSE: begin
                  number_next = cmd_q.idx;
                  second_next = 1'b0;
                  state_next  = S_SETUP;
               end
               OP_CLEAR: begin
                  scan_next  = '0;
                  state_next = S_SCAN;
               end
               OP_INVALID: begin
                  if (err_count != 8'hFF) err_next = err_count + 8'd1;
                  state_next = S_IDLE;
               end
            endcase
         end
         S_SETUP: begin
            // The mirror flips together with the rising edge the decoder will see.
            mirror_next[number] = ~mirror[number];
            timer_next          = TW'(PULSE_LEN - 1);
            state_next          = S_STROBE;
         end
         S_STROBE: begin
            if (timer == '0) begin
               timer_next = TW'(GAP_LEN - 1);
               state_next = S_GAP;
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         S_GAP: begin
            if (timer != '0) begin
               timer_next = timer - TW'(1);
            end else if (op_q == OP_PULSE && !second_q) begin
               second_next = 1'b1;
               timer_next  = TW'(HOLD_LEN - 1);
               state_next  = S_HOLD;
            end else if (op_q == OP_CLEAR && scan_idx != 4'hF) begin
               scan_next  = scan_idx + 4'd1;
               state_next = S_SCAN;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_HOLD: begin
            if (timer == '0) state_next = S_SETUP;
            else             timer_next = timer - TW'(1);
         end
         S_SCAN: begin
            if (mirror[scan_idx] != DEFAULT_STATE[scan_idx]) begin
               number_next = scan_idx;
               state_next  = S_SETUP;
            end else if (scan_idx == 4'hF) begin
               state_next = S_IDLE;
            end else begin
               scan_next = scan_idx + 4'd1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_q     <= '0;
         op_q      <= OP_TOGGLE;
         second_q  <= 1'b0;
         timer     <= '0;
         scan_idx  <= '0;
         number    <= '0;
         control   <= 1'b0;
         mirror    <= DEFAULT_STATE;
         err_count <= '0;
      end else begin
         if (pop) cmd_q <= fifo_mem[rd_ptr];
         state     <= state_next;
         op_q      <= op_next;
         second_q  <= second_next;
         timer     <= timer_next;
         scan_idx  <= scan_next;
         number    <= number_next;
         // Registered so the decoder never sees a decode glitch on its edge-sensitive input.
         control   <= (state_next == S_STROBE);
         mirror    <= mirror_next;
         err_count <= err_next;
      end
   end

endmodule

// File: doc/virtual_input_sequencer.md
Name: virtual_input_sequencer

Overview:
Command scheduler that drives the virtual button/switch decoder's `number[3:0]` and `control` inputs. It buffers host command bytes in a small FIFO and converts each into correctly timed toggle strobes: setup, then high pulse, then low gap. The decoder is rising-edge triggered on `control`, so strobes must be clean and well separated. It also tracks a mirror of the expected decoder state, which allows auto-release "press" pulses and a "restore defaults" sweep. It sits between the host byte receiver (UART/JTAG side) and the decoder.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- PULSE_LEN, 4: cycles `control` is held high per strobe; minimum 1.
- GAP_LEN, 4: cycles `control` is held low after each strobe; minimum 1.
- HOLD_LEN, 1000: cycles between the two strobes of a PULSE command; 1..65535.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cmd_data  input  8  command byte. [7:6] opcode: 00 TOGGLE, 01 PULSE, 10 CLEAR, 11 invalid. [5:4] ignored. [3:0] index.
- cmd_valid  input  1  cmd_data is valid.
- cmd_ready  output  1  FIFO can accept a byte.
- number  output  4  index presented to the decoder.
- control  output  1  strobe to the decoder; its rising edge triggers the toggle.
- busy  output  1  FSM not in IDLE, or FIFO non-empty.
- mirror  output  16  expected decoder state; bit i corresponds to index i.
- err_count  output  8  count of invalid opcodes, saturating.

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle, 1 after; number=0; control=0; busy=0; err_count=0; mirror=16'h000F (indices 0-3 are buttons, idle high; indices 4-15 are switches, low). FIFO is flushed and the FSM goes to IDLE.
- Reset mid-operation: control drops to 0 at the next edge, and queued commands are discarded. The decoder itself is not reset; the system must power it up in the default state.
- Handshake: a byte is accepted on an edge where cmd_valid && cmd_ready. cmd_ready = !fifo_full, registered from FIFO occupancy.
  - When full, no push is accepted, even if a pop happens in the same cycle.
  - Push and pop in the same cycle while non-full and non-empty both take effect.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head and decode the opcode.
    - TOGGLE or PULSE: latch the index into number, go to SETUP.
    - CLEAR: scan index := 0, go to SCAN.
    - Invalid: err_count += 1, saturating at 255; byte dropped; stay in IDLE. Exactly one cycle is consumed.
  - SETUP (1 cycle): number is stable, control=0.
  - STROBE (PULSE_LEN cycles): control=1. mirror[number] inverts on the edge entering STROBE.
  - GAP (GAP_LEN cycles): control=0. Then:
    - For PULSE on its first strobe: go to HOLD.
    - For CLEAR: go to SCAN with index+1, or to IDLE if index=15.
    - Otherwise: go to IDLE.
  - HOLD (HOLD_LEN cycles): control=0; then SETUP for the second strobe on the same index.
  - SCAN (1 cycle per index): if mirror[i] differs from default[i], set number=i and go to SETUP. Otherwise advance; after i=15, go to IDLE.
- Invariants:
  - number changes only in IDLE and SCAN, never while control=1 or in GAP.
  - control is never high in two adjacent strobes without at least GAP_LEN low cycles between them.
- Latency: for a TOGGLE accepted at edge t into an empty FIFO with the FSM in IDLE:
  - pop at t+1;
  - SETUP during cycle t+2;
  - control rises at edge t+3 and stays high for PULSE_LEN cycles.
- TOGGLE duration: 1 + PULSE_LEN + GAP_LEN cycles.
- PULSE duration: 2×(1 + PULSE_LEN + GAP_LEN) + HOLD_LEN cycles. PULSE returns mirror to its original value.
- CLEAR with mirror already at default: 16 SCAN cycles, no strobes.
- Index width is 4 bits, so all 16 values are legal; there is no out-of-range case.

Test Plan:
- Reset, then TOGGLE idx 5 (8'h05) -> control rises 3 cycles after accept, number=5 throughout, high 4 cycles; mirror=16'h002F; busy drops after GAP.
- PULSE idx 1 (8'h41) with HOLD_LEN=20 -> two 4-cycle strobes on number=1, separated by 4+20+1 low cycles; mirror ends at 16'h000F.
- TOGGLE 0, TOGGLE 9, then CLEAR (8'h80) -> CLEAR emits strobes on number 0 then 9 only; mirror ends at 16'h000F.
- Send 8'hC3, then 8'h02 -> err_count=1; 8'hC3 produces no strobe; the following TOGGLE 2 executes normally.
- Push 7 back-to-back bytes with cmd_valid held high -> cmd_ready deasserts once 4 are queued; no byte is lost or duplicated; all 7 execute in order.
- Assert reset during STROBE of a PULSE -> control=0 at the next edge; mirror=16'h000F; FIFO empty; no further strobes.
